// File: rtl/battle_turn_ctrl.sv
// battle_turn_ctrl: sequences one player-vs-CPU battle turn and shares one damage unit between both attackers.
// Optional macro ACCURACY_EN adds an LFSR hit/miss roll per attack; without it every attack hits.
module battle_turn_ctrl #(
    parameter int unsigned HP_W        = 8,
    parameter int unsigned CPU_TIMEOUT = 64,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            start,
    input  logic [HP_W-1:0] player_hp_init,
    input  logic [HP_W-1:0] CPU_hp_init,
    input  logic [HP_W-1:0] player_speed,
    input  logic [HP_W-1:0] CPU_speed,
    input  logic            player_move_valid,
    input  logic [1:0]      player_move,
    output logic            player_ready,
    output logic            CPU_turn,
    input  logic            CPU_done,
    input  logic [1:0]      cpu_move,
    output logic            dmg_req,
    output logic            dmg_attacker,
    output logic [1:0]      dmg_move,
    input  logic            dmg_ack,
    input  logic [HP_W-1:0] dmg_value,
    input  logic [HP_W-1:0] move_acc,
    output logic [HP_W-1:0] player_hp,
    output logic [HP_W-1:0] CPU_hp,
    output logic            miss,
    output logic            turn_done,
    output logic            battle_over,
    output logic [1:0]      winner
);

    // state       | meaning
    // IDLE        | no battle loaded
    // WAIT_PLAYER | waiting for the player's move
    // WAIT_CPU    | AI choosing, bounded by CPU_TIMEOUT
    // ORDER       | pick first attacker by speed
    // ATK_REQ     | damage unit requested for current attacker
    // ATK_APPLY   | subtract damage from defender
    // TURN_END    | turn_done pulse, faint check
    // OVER        | battle finished, winner held
    typedef enum logic [2:0] {
        IDLE, WAIT_PLAYER, WAIT_CPU, ORDER, ATK_REQ, ATK_APPLY, TURN_END, OVER
    } state_t;

    localparam int unsigned CNT_W = $clog2(CPU_TIMEOUT + 1);

    state_t          state_q, state_d;
    logic [1:0]      ply_mv_q, ply_mv_d;
    logic [1:0]      cpu_mv_q, cpu_mv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            slot_q, slot_d;
    logic [HP_W-1:0] dmg_q, dmg_d;
    logic [HP_W-1:0] player_hp_q, player_hp_d;
    logic [HP_W-1:0] cpu_hp_q, cpu_hp_d;
    logic            player_ready_q, player_ready_d;
    logic            cpu_turn_q, cpu_turn_d;
    logic            dmg_req_q, dmg_req_d;
    logic            dmg_attacker_q, dmg_attacker_d;
    logic [1:0]      dmg_move_q, dmg_move_d;
    logic            turn_done_q, turn_done_d;
    logic            battle_over_q, battle_over_d;
    logic [1:0]      winner_q, winner_d;
    logic [HP_W-1:0] def_hp, eff_dmg, new_hp;

`ifdef ACCURACY_EN
    logic [7:0] lfsr_q, lfsr_d;
    logic       hit_q, hit_d;
    logic       miss_q, miss_d;
`else
    logic       unused_cfg;
    assign unused_cfg = ^{move_acc, LFSR_SEED};
`endif

    always_comb begin
        state_d        = state_q;
        ply_mv_d       = ply_mv_q;
        cpu_mv_d       = cpu_mv_q;
        cnt_d          = cnt_q;
        slot_d         = slot_q;
        dmg_d          = dmg_q;
        player_hp_d    = player_hp_q;
        cpu_hp_d       = cpu_hp_q;
        dmg_attacker_d = dmg_attacker_q;
        dmg_move_d     = dmg_move_q;
        winner_d       = winner_q;
`ifdef ACCURACY_EN
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        hit_d   = hit_q;
        eff_dmg = hit_q ? dmg_q : '0;
`else
        eff_dmg = dmg_q;
`endif
        def_hp = dmg_attacker_q ? player_hp_q : cpu_hp_q;
        new_hp = (def_hp > eff_dmg) ? def_hp - eff_dmg : '0;

        case (state_q)
            IDLE: ;
            WAIT_PLAYER: begin
                if (player_move_valid) begin
                    ply_mv_d = player_move;
                    cnt_d    = CNT_W'(CPU_TIMEOUT - 1);
                    state_d  = WAIT_CPU;
                end
            end
            WAIT_CPU: begin
                // CPU_done is checked first so it wins on the last timeout cycle
                if (CPU_done) begin
                    cpu_mv_d = cpu_move;
                    state_d  = ORDER;
                end else if (cnt_q == '0) begin
                    cpu_mv_d = 2'd0;
                    state_d  = ORDER;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ORDER: begin
                dmg_attacker_d = (player_speed < CPU_speed);
                dmg_move_d     = (player_speed < CPU_speed) ? cpu_mv_q : ply_mv_q;
                slot_d         = 1'b0;
                state_d        = ATK_REQ;
            end
            ATK_REQ: begin
                if (dmg_ack) begin
                    dmg_d   = dmg_value;
`ifdef ACCURACY_EN
                    hit_d   = (move_acc >= HP_W'(100)) || (HP_W'(lfsr_q[6:0]) < move_acc);
`endif
                    state_d = ATK_APPLY;
                end
            end
            ATK_APPLY: begin
                if (dmg_attacker_q) player_hp_d = new_hp;
                else                cpu_hp_d    = new_hp;
                if (new_hp == '0 || slot_q) begin
                    state_d = TURN_END;
                end else begin
                    slot_d         = 1'b1;
                    dmg_attacker_d = ~dmg_attacker_q;
                    dmg_move_d     = dmg_attacker_q ? ply_mv_q : cpu_mv_q;
                    state_d        = ATK_REQ;
                end
            end
            TURN_END: begin
                if (player_hp_q == '0) begin
                    winner_d = 2'b10;
                    state_d  = OVER;
                end else if (cpu_hp_q == '0) begin
                    winner_d = 2'b01;
                    state_d  = OVER;
                end else begin
                    state_d = WAIT_PLAYER;
                end
            end
            OVER: ;
            default: state_d = IDLE;
        endcase

        if (start) begin
            player_hp_d = player_hp_init;
            cpu_hp_d    = CPU_hp_init;
            winner_d    = 2'b00;
            slot_d      = 1'b0;
            state_d     = WAIT_PLAYER;
        end

        player_ready_d = (state_d == WAIT_PLAYER);
        cpu_turn_d     = (state_d == WAIT_CPU);
        dmg_req_d      = (state_d == ATK_REQ);
        turn_done_d    = (state_d == TURN_END);
        battle_over_d  = (state_d == OVER);
`ifdef ACCURACY_EN
        miss_d = (state_d == ATK_APPLY) && !hit_d;
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            ply_mv_q       <= '0;
            cpu_mv_q       <= '0;
            cnt_q          <= '0;
            slot_q         <= 1'b0;
            dmg_q          <= '0;
            player_hp_q    <= '0;
            cpu_hp_q       <= '0;
            player_ready_q <= 1'b0;
            cpu_turn_q     <= 1'b0;
            dmg_req_q      <= 1'b0;
            dmg_attacker_q <= 1'b0;
            dmg_move_q     <= '0;
            turn_done_q    <= 1'b0;
            battle_over_q  <= 1'b0;
            winner_q       <= '0;
`ifdef ACCURACY_EN
            lfsr_q         <= LFSR_SEED;
            hit_q          <= 1'b0;
            miss_q         <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            ply_mv_q       <= ply_mv_d;
            cpu_mv_q       <= cpu_mv_d;
            cnt_q          <= cnt_d;
            slot_q         <= slot_d;
            dmg_q          <= dmg_d;
            player_hp_q    <= player_hp_d;
            cpu_hp_q       <= cpu_hp_d;
            player_ready_q <= player_ready_d;
            cpu_turn_q     <= cpu_turn_d;
            dmg_req_q      <= dmg_req_d;
            dmg_attacker_q <= dmg_attacker_d;
            dmg_move_q     <= dmg_move_d;
            turn_done_q    <= turn_done_d;
            battle_over_q  <= battle_over_d;
            winner_q       <= winner_d;
`ifdef ACCURACY_EN
            lfsr_q         <= lfsr_d;
            hit_q          <= hit_d;
            miss_q         <= miss_d;
`endif
        end
    end

    assign player_ready = player_ready_q;
    assign CPU_turn     = cpu_turn_q;
    assign dmg_req      = dmg_req_q;
    assign dmg_attacker = dmg_attacker_q;
    assign dmg_move     = dmg_move_q;
    assign player_hp    = player_hp_q;
    assign CPU_hp       = cpu_hp_q;
    assign turn_done    = turn_done_q;
    assign battle_over  = battle_over_q;
    assign winner       = winner_q;
`ifdef ACCURACY_EN
    assign miss = miss_q;
`else
    assign miss = 1'b0;
`endif

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// tb_battle_turn_ctrl: directed spec scenarios plus randomized battles against a turn-level reference model.
module tb_battle_turn_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, start;
    logic [7:0] player_hp_init, CPU_hp_init, player_speed, CPU_speed;
    logic       player_move_valid;
    logic [1:0] player_move;
    logic       player_ready, CPU_turn, CPU_done;
    logic [1:0] cpu_move;
    logic       dmg_req, dmg_attacker;
    logic [1:0] dmg_move;
    logic       dmg_ack;
    logic [7:0] dmg_value, move_acc;
    logic [7:0] player_hp, CPU_hp;
    logic       miss, turn_done, battle_over;
    logic [1:0] winner;

    battle_turn_ctrl dut (
        .Clk(Clk), .Reset(Reset), .start(start),
        .player_hp_init(player_hp_init), .CPU_hp_init(CPU_hp_init),
        .player_speed(player_speed), .CPU_speed(CPU_speed),
        .player_move_valid(player_move_valid), .player_move(player_move),
        .player_ready(player_ready), .CPU_turn(CPU_turn),
        .CPU_done(CPU_done), .cpu_move(cpu_move),
        .dmg_req(dmg_req), .dmg_attacker(dmg_attacker), .dmg_move(dmg_move),
        .dmg_ack(dmg_ack), .dmg_value(dmg_value), .move_acc(move_acc),
        .player_hp(player_hp), .CPU_hp(CPU_hp), .miss(miss),
        .turn_done(turn_done), .battle_over(battle_over), .winner(winner)
    );

    always #5 Clk = ~Clk;

    int cyc  = 0;
    int n_hs = 0;
    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (dmg_req && dmg_ack) n_hs <= n_hs + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int m_php, m_chp;
    bit m_over;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit will_hit(input logic [7:0] acc);
`ifdef ACCURACY_EN
        return acc >= 8'd100;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [7:0] pick_acc();
`ifdef ACCURACY_EN
        case ($urandom_range(2))
            0:       return 8'd0;
            1:       return 8'd100;
            default: return 8'(100 + $urandom_range(155));
        endcase
`else
        return 8'($urandom);
`endif
    endfunction

    task automatic start_battle(input int php, input int chp);
        @(negedge Clk);
        start = 1'b1; player_hp_init = 8'(php); CPU_hp_init = 8'(chp);
        @(negedge Clk);
        start = 1'b0; player_hp_init = 8'($urandom); CPU_hp_init = 8'($urandom);
        m_php = php; m_chp = chp; m_over = 1'b0;
        check_eq("start_player_hp", player_hp, m_php);
        check_eq("start_cpu_hp", CPU_hp, m_chp);
        check_eq("start_ready", player_ready, 1);
        check_eq("start_over_winner", {battle_over, winner}, 0);
    endtask

    // cpu_dly: cycle of CPU_turn on which CPU_done is raised; negative means never
    task automatic run_turn(input logic [1:0] pm, input logic [1:0] cm, input int cpu_dly,
                            input int ack_dly, input int dmg_p, input int dmg_c,
                            input logic [7:0] acc_p, input logic [7:0] acc_c, input bit chk_lat);
        int n, t0, hs0, exp_hi, n_att, eff, dmg;
        bit att, hit, first_cpu, ai_on_time;
        logic [1:0] exp_cm;
        n = 0;
        while (player_ready !== 1'b1 && n < 16) begin @(negedge Clk); n++; end
        check_eq("ready", player_ready, 1);
        t0 = cyc; hs0 = n_hs;
        player_move_valid = 1'b1; player_move = pm;
        @(negedge Clk);
        player_move_valid = 1'b0; player_move = 2'($urandom);

        ai_on_time = (cpu_dly >= 0 && cpu_dly < 64);
        exp_hi = ai_on_time ? cpu_dly + 1 : 64;
        exp_cm = ai_on_time ? cm : 2'd0;
        n = 0;
        while (CPU_turn === 1'b1 && n < 100) begin
            CPU_done = (n == cpu_dly);
            cpu_move = (n == cpu_dly) ? cm : 2'($urandom);
            @(negedge Clk);
            n++;
        end
        CPU_done = 1'b0;
        check_eq("cpu_turn_cycles", n, exp_hi);

        first_cpu = !(player_speed >= CPU_speed);
        n_att = 0;
        for (int k = 0; k < 2; k++) begin
            att = first_cpu ^ k[0];
            n = 0;
            while (dmg_req !== 1'b1 && n < 8) begin @(negedge Clk); n++; end
            check_eq("dmg_req", dmg_req, 1);
            check_eq("dmg_attacker", dmg_attacker, att);
            check_eq("dmg_move", dmg_move, att ? exp_cm : pm);
            for (int w = 0; w < ack_dly; w++) begin
                @(negedge Clk);
                check_eq("req_hold", {dmg_req, dmg_attacker, dmg_move},
                         {1'b1, att, att ? exp_cm : pm});
            end
            dmg = att ? dmg_c : dmg_p;
            dmg_ack = 1'b1; dmg_value = 8'(dmg); move_acc = att ? acc_c : acc_p;
            hit = will_hit(move_acc);
            @(negedge Clk);
            dmg_ack = 1'b0; dmg_value = 8'($urandom); move_acc = 8'($urandom);
            check_eq("req_drop", dmg_req, 0);
            check_eq("miss", miss, !hit);
            eff = hit ? dmg : 0;
            n_att++;
            if (att) begin
                m_php = m_php - eff; if (m_php < 0) m_php = 0;
            end else begin
                m_chp = m_chp - eff; if (m_chp < 0) m_chp = 0;
            end
            if ((att ? m_php : m_chp) == 0) break;
        end

        @(negedge Clk);
        check_eq("turn_done", turn_done, 1);
        check_eq("attack_count", n_hs - hs0, n_att);
        check_eq("player_hp", player_hp, m_php);
        check_eq("cpu_hp", CPU_hp, m_chp);
        if (chk_lat) check_eq("latency", cyc - t0, 7);
        @(negedge Clk);
        check_eq("turn_done_pulse", turn_done, 0);
        if (m_php == 0) begin
            m_over = 1'b1;
            check_eq("winner", winner, 2);
        end else if (m_chp == 0) begin
            m_over = 1'b1;
            check_eq("winner", winner, 1);
        end else begin
            check_eq("ready_next", player_ready, 1);
            check_eq("winner", winner, 0);
        end
        check_eq("battle_over", battle_over, m_over);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, cd, php, chp;
        Reset = 1'b1; start = 1'b0;
        player_hp_init = '0; CPU_hp_init = '0; player_speed = '0; CPU_speed = '0;
        player_move_valid = 1'b0; player_move = '0; CPU_done = 1'b0; cpu_move = '0;
        dmg_ack = 1'b0; dmg_value = '0; move_acc = '0;
        repeat (3) @(negedge Clk);
        check_eq("rst_strobes", {player_ready, CPU_turn, dmg_req, miss, turn_done}, 0);
        check_eq("rst_over_winner", {battle_over, winner}, 0);
        check_eq("rst_dmg_out", {dmg_attacker, dmg_move}, 0);
        check_eq("rst_hp", {player_hp, CPU_hp}, 0);
        Reset = 1'b0;
        @(negedge Clk);
        check_eq("idle_ready", player_ready, 0);

        // speed order, both attacks land, latency with immediate AI and 1-cycle ack
        player_speed = 8'd50; CPU_speed = 8'd40;
        start_battle(100, 100);
        run_turn(2'd1, 2'd2, 0, 0, 30, 30, 8'd100, 8'd100, 1'b1);

        // faint skips the CPU reply
        start_battle(100, 20);
        run_turn(2'd3, 2'd1, 1, 1, 25, 10, 8'd100, 8'd100, 1'b0);

        // tie goes to player, CPU damage saturates player HP at 0
        player_speed = 8'd30; CPU_speed = 8'd30;
        start_battle(5, 100);
        run_turn(2'd2, 2'd3, 2, 2, 10, 200, 8'd100, 8'd100, 1'b0);

        // AI timeout forces CPU move 0; CPU faster; then done on the last timeout cycle
        player_speed = 8'd10; CPU_speed = 8'd60;
        start_battle(100, 100);
        run_turn(2'd3, 2'd2, -1, 0, 5, 7, 8'd100, 8'd100, 1'b0);
        run_turn(2'd1, 2'd3, 63, 1, 5, 7, 8'd100, 8'd100, 1'b0);

        // zero accuracy: hits without the accuracy feature, misses with it
        start_battle(100, 100);
        run_turn(2'd0, 2'd1, 0, 0, 11, 13, 8'd0, 8'd0, 1'b0);

        // HP loaded as zero ends the battle at the first turn end
        start_battle(0, 0);
        run_turn(2'd1, 2'd1, 0, 0, 0, 0, 8'd100, 8'd100, 1'b0);

        // reset while a damage request is pending, late ack ignored
        start_battle(50, 50);
        player_move_valid = 1'b1; player_move = 2'd1;
        @(negedge Clk);
        player_move_valid = 1'b0; CPU_done = 1'b1; cpu_move = 2'd2;
        @(negedge Clk);
        CPU_done = 1'b0;
        n = 0;
        while (dmg_req !== 1'b1 && n < 8) begin @(negedge Clk); n++; end
        check_eq("pre_rst_req", dmg_req, 1);
        Reset = 1'b1;
        @(negedge Clk);
        check_eq("rst_mid_req", dmg_req, 0);
        check_eq("rst_mid_hp", {player_hp, CPU_hp}, 0);
        check_eq("rst_mid_ready", player_ready, 0);
        Reset = 1'b0; dmg_ack = 1'b1; dmg_value = 8'd9;
        repeat (2) @(negedge Clk);
        dmg_ack = 1'b0;
        check_eq("late_ack_hp", {player_hp, CPU_hp}, 0);
        check_eq("late_ack_strobes", {dmg_req, turn_done, player_ready, miss}, 0);

        // randomized battles
        for (int b = 0; b < 25; b++) begin
            player_speed = 8'($urandom);
            CPU_speed    = ($urandom_range(3) == 0) ? player_speed : 8'($urandom);
            php = ($urandom_range(15) == 0) ? 0 : $urandom_range(1, 120);
            chp = ($urandom_range(15) == 0) ? 0 : $urandom_range(1, 120);
            start_battle(php, chp);
            for (int t = 0; t < 8 && !m_over; t++) begin
                case ($urandom_range(19))
                    0:       cd = -1;
                    1:       cd = 63;
                    default: cd = $urandom_range(0, 4);
                endcase
                run_turn(2'($urandom), 2'($urandom), cd, $urandom_range(0, 3),
                         ($urandom_range(7) == 0) ? 200 : $urandom_range(0, 60),
                         ($urandom_range(7) == 0) ? 255 : $urandom_range(0, 60),
                         pick_acc(), pick_acc(), 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
